// File: rtl/count_seq_pkg.sv
// Shared types and defaults for the count sequencer.
// State encoding plus default count and prescaler widths.
package count_seq_pkg;

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_PRESCALE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_e;

endpackage

// File: rtl/count_sequencer_tick_prescaler.sv
// Tick prescaler: captures a divisor on run entry, then
// emits one tick every div+1 run cycles; holds when not running.
module tick_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear_i,
    input  logic                  run_i,
    input  logic [PRESCALE_W-1:0] div_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] div_q, div_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (clear_i) begin
            div_d = div_i;
            cnt_d = '0;
        end else if (run_i) begin
            if (cnt_q == '0) begin
                tick_o = 1'b1;
                cnt_d  = div_q;
            end else begin
                cnt_d = cnt_q - PRESCALE_W'(1);
            end
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Start/stop/load counter with terminal detect and auto-reload.
// Optional tick prescaler enabled by COUNT_SEQUENCER_PRESCALE_EN.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic [WIDTH-1:0]      terminal,
    input  logic                  auto_reload,
    input  logic [PRESCALE_W-1:0] presc_div,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             busy_q, done_q, done_d, wrap_q, wrap_d;
    logic             tick, entry;

`ifdef COUNT_SEQUENCER_PRESCALE_EN
    tick_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_presc (
        .clock  (clock),
        .reset_n(reset_n),
        .clear_i(entry),
        .run_i  (state_q == S_RUN),
        .div_i  (presc_div),
        .tick_o (tick)
    );
`else
    logic unused_presc;
    assign unused_presc = ^presc_div;
    assign tick         = (state_q == S_RUN);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= (state_d == S_RUN) || (state_d == S_PAUSE);
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        entry   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (load) count_d = load_value;
                if (start) begin
                    state_d = S_RUN;
                    entry   = 1'b1;
                end
            end
            S_RUN: begin
                if (stop) state_d = S_PAUSE;
                if (tick && count_q == terminal) begin
                    done_d = 1'b1;
                    if (auto_reload) begin
                        count_d = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (tick) begin
                    count_d = count_q + WIDTH'(1);
                    wrap_d  = &count_q;
                end
            end
            S_PAUSE: begin
                if (load) count_d = load_value;
                if (start && !stop) state_d = S_RUN;
            end
            S_DONE: begin
                if (load) count_d = load_value;
                if (start) begin
                    state_d = S_RUN;
                    entry   = 1'b1;
                    if (!load) count_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign wrap  = wrap_q;

endmodule
